// File: rtl/soul_mover.sv
// Player-soul controller: keyboard-driven movement clamped to the battle box,
// post-hit invincibility with blinking, and sprite hit-test / ROM addressing.
module soul_mover #(
    parameter int X_INIT        = 319,
    parameter int Y_INIT        = 317,
    parameter int X_MIN         = 251,
    parameter int X_MAX         = 390,
    parameter int Y_MIN         = 252,
    parameter int Y_MAX         = 366,
    parameter int STEP          = 1,
    parameter int SPRITE_W      = 16,
    parameter int SPRITE_H      = 16,
    parameter int ACTIVE_STATUS = 5,
    parameter int HIT_FRAMES    = 60,
    parameter int BLINK_BIT     = 2
) (
    input  logic                                  Clk,
    input  logic                                  Reset,
    input  logic                                  frame_clk,
    input  logic [3:0]                            status,
    input  logic [7:0]                            keycode0,
    input  logic [7:0]                            keycode1,
    input  logic                                  hit,
    input  logic [9:0]                            DrawX,
    input  logic [9:0]                            DrawY,
    output logic [9:0]                            PosX,
    output logic [9:0]                            PosY,
    output logic                                  is_sprite,
    output logic [$clog2(SPRITE_W*SPRITE_H)-1:0]  sprite_address,
    output logic                                  invincible
);

    localparam int XW    = $clog2(SPRITE_W);
    localparam int YW    = $clog2(SPRITE_H);
    localparam int CNT_W = ($clog2(HIT_FRAMES + 1) > BLINK_BIT + 1) ?
                           $clog2(HIT_FRAMES + 1) : BLINK_BIT + 1;

    localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
    localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
    localparam logic signed [10:0] YMIN_S = 11'(Y_MIN);
    localparam logic signed [10:0] YMAX_S = 11'(Y_MAX);
    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic signed [10:0] W_S    = 11'(SPRITE_W);
    localparam logic signed [10:0] H_S    = 11'(SPRITE_H);
    localparam logic signed [10:0] HW_S   = 11'(SPRITE_W / 2);
    localparam logic signed [10:0] HH_S   = 11'(SPRITE_H / 2);

    typedef enum logic [1:0] {IDLE, LIVE, HURT} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               f_d;
    logic               tick;

    logic               up, down, left, right;
    logic signed [10:0] pos_x_s, pos_y_s;
    logic signed [10:0] nx_s, ny_s;
    logic signed [10:0] dx, dy;
    logic               in_box;

    function automatic logic [9:0] clamp(input logic signed [10:0] v,
                                         input logic signed [10:0] lo,
                                         input logic signed [10:0] hi);
        logic signed [10:0] r;
        r = v;
        if (v < lo)
            r = lo;
        else if (v > hi)
            r = hi;
        return r[9:0];
    endfunction

    // Direction is the OR of both keycodes; opposing keys cancel per axis.
    always_comb begin
        up    = (keycode0 == 8'd26) || (keycode1 == 8'd26);
        left  = (keycode0 == 8'd4)  || (keycode1 == 8'd4);
        down  = (keycode0 == 8'd22) || (keycode1 == 8'd22);
        right = (keycode0 == 8'd7)  || (keycode1 == 8'd7);

        pos_x_s = signed'({1'b0, PosX});
        pos_y_s = signed'({1'b0, PosY});
        nx_s    = pos_x_s;
        ny_s    = pos_y_s;
        if (right && !left)
            nx_s = pos_x_s + STEP_S;
        else if (left && !right)
            nx_s = pos_x_s - STEP_S;
        if (down && !up)
            ny_s = pos_y_s + STEP_S;
        else if (up && !down)
            ny_s = pos_y_s - STEP_S;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            f_d   <= 1'b0;
            tick  <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            PosX  <= 10'(X_INIT);
            PosY  <= 10'(Y_INIT);
        end else begin
            f_d  <= frame_clk;
            tick <= frame_clk & ~f_d;
            if (status != 4'(ACTIVE_STATUS)) begin
                state <= IDLE;
                cnt   <= '0;
                PosX  <= 10'(X_INIT);
                PosY  <= 10'(Y_INIT);
            end else begin
                if (state != IDLE && tick) begin
                    PosX <= clamp(nx_s, XMIN_S, XMAX_S);
                    PosY <= clamp(ny_s, YMIN_S, YMAX_S);
                end
                case (state)
                    IDLE: state <= LIVE;
                    LIVE: begin
                        // A hit on a tick cycle loads the full window without decrementing.
                        if (hit) begin
                            state <= HURT;
                            cnt   <= CNT_W'(HIT_FRAMES);
                        end
                    end
                    HURT: begin
                        if (tick) begin
                            cnt <= cnt - 1'b1;
                            if (cnt == CNT_W'(1))
                                state <= LIVE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Sprite-local coordinates; negative or oversized values fall outside the box.
    always_comb begin
        dx     = signed'({1'b0, DrawX}) - signed'({1'b0, PosX}) + HW_S;
        dy     = signed'({1'b0, DrawY}) - signed'({1'b0, PosY}) + HH_S;
        in_box = (dx >= 0) && (dx < W_S) && (dy >= 0) && (dy < H_S);
    end

    assign is_sprite      = in_box && (state != IDLE) && !((state == HURT) && cnt[BLINK_BIT]);
    assign sprite_address = in_box ? {dy[YW-1:0], dx[XW-1:0]} : '0;
    assign invincible     = (state == HURT);

endmodule

// File: tb/tb_soul_mover.sv
// Scoreboard bench for soul_mover: a frame-level reference model queues the
// expected outputs each cycle and a negedge monitor compares them.
module tb_soul_mover;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [3:0] status = 4'd0;
    logic [7:0] keycode0 = 8'd0, keycode1 = 8'd0;
    logic       hit = 1'b0;
    logic [9:0] DrawX = 10'd319, DrawY = 10'd317;
    logic [9:0] PosX, PosY, PosX4, PosY4;
    logic       is_sprite, invincible, is_sprite4, invincible4;
    logic [7:0] sprite_address, sprite_address4;

    soul_mover dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .status(status),
        .keycode0(keycode0), .keycode1(keycode1), .hit(hit),
        .DrawX(DrawX), .DrawY(DrawY), .PosX(PosX), .PosY(PosY),
        .is_sprite(is_sprite), .sprite_address(sprite_address), .invincible(invincible)
    );

    soul_mover #(.STEP(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .status(status),
        .keycode0(keycode0), .keycode1(keycode1), .hit(hit),
        .DrawX(DrawX), .DrawY(DrawY), .PosX(PosX4), .PosY(PosY4),
        .is_sprite(is_sprite4), .sprite_address(sprite_address4), .invincible(invincible4)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int x, y, x4, y4;
        bit inv, spr;
        int addr;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   npass = 0;
    int   ntotal = 0;

    // Reference model state: mode 0 idle, 1 live, 2 hurt.
    int mx, my, mx4, my4, mode, mcnt;
    bit m_fd, m_tick;

    task automatic chk(input string name, input int act, input int req);
        ntotal++;
        if (act == req)
            npass++;
        else
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    endtask

    always @(negedge Clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("PosX", int'(PosX), mon_e.x);
            chk("PosY", int'(PosY), mon_e.y);
            chk("invincible", int'(invincible), int'(mon_e.inv));
            chk("is_sprite", int'(is_sprite), int'(mon_e.spr));
            chk("sprite_address", int'(sprite_address), mon_e.addr);
            chk("PosX_step4", int'(PosX4), mon_e.x4);
            chk("PosY_step4", int'(PosY4), mon_e.y4);
        end
    end

    function automatic int mv(input int p, input bit neg, input bit pos,
                              input int step, input int lo, input int hi);
        int r;
        r = p;
        if (pos && !neg) r = p + step;
        if (neg && !pos) r = p - step;
        if (r < lo) r = lo;
        if (r > hi) r = hi;
        return r;
    endfunction

    function automatic bit has(input int k0, input int k1, input int code);
        return (k0 == code) || (k1 == code);
    endfunction

    task automatic model_reset();
        mx = 319; my = 317; mx4 = 319; my4 = 317;
        mode = 0; mcnt = 0; m_fd = 0; m_tick = 0;
    endtask

    // Outputs the DUT should present now, given the model state and current pixel.
    task automatic push_expected(input int drx, input int dry);
        exp_t e;
        int ax, ay;
        bit inb;
        ax = drx - mx + 8;
        ay = dry - my + 8;
        inb = (ax >= 0) && (ax < 16) && (ay >= 0) && (ay < 16);
        e.x = mx; e.y = my; e.x4 = mx4; e.y4 = my4;
        e.inv = (mode == 2);
        e.spr = inb && (mode != 0) && !((mode == 2) && (((mcnt >> 2) & 1) == 1));
        e.addr = inb ? ay * 16 + ax : 0;
        q.push_back(e);
    endtask

    // Effect of one clock edge with the given inputs on the frame-level state.
    task automatic model_edge(input bit rst, input bit fr, input int st,
                              input int k0, input int k1, input bit h);
        bit tk;
        if (rst) begin
            model_reset();
        end else begin
            tk = m_tick;
            m_tick = fr && !m_fd;
            m_fd = fr;
            if (st != 5) begin
                mode = 0; mcnt = 0;
                mx = 319; my = 317; mx4 = 319; my4 = 317;
            end else if (mode == 0) begin
                mode = 1;
            end else begin
                if (tk) begin
                    mx  = mv(mx,  has(k0, k1, 4),  has(k0, k1, 7),  1, 251, 390);
                    my  = mv(my,  has(k0, k1, 26), has(k0, k1, 22), 1, 252, 366);
                    mx4 = mv(mx4, has(k0, k1, 4),  has(k0, k1, 7),  4, 251, 390);
                    my4 = mv(my4, has(k0, k1, 26), has(k0, k1, 22), 4, 252, 366);
                end
                if (mode == 1 && h) begin
                    mode = 2; mcnt = 60;
                end else if (mode == 2 && tk) begin
                    mcnt = mcnt - 1;
                    if (mcnt == 0) mode = 1;
                end
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit fr, input int st, input int k0,
                         input int k1, input bit h, input int drx, input int dry);
        @(posedge Clk);
        #1;
        Reset = rst; frame_clk = fr; status = 4'(st);
        keycode0 = 8'(k0); keycode1 = 8'(k1); hit = h;
        DrawX = 10'(drx); DrawY = 10'(dry);
        push_expected(drx, dry);
        model_edge(rst, fr, st, k0, k1, h);
    endtask

    task automatic ticks(input int n, input int st, input int k0, input int k1);
        for (int i = 0; i < n; i++) begin
            cycle(0, 1, st, k0, k1, 0, 319, 317);
            cycle(0, 0, st, k0, k1, 0, 319, 317);
        end
    endtask

    initial begin
        int kc_tab[6];
        bit fr;
        int st, k0, k1, drx, dry;
        kc_tab[0] = 0; kc_tab[1] = 4; kc_tab[2] = 7;
        kc_tab[3] = 22; kc_tab[4] = 26; kc_tab[5] = 9;
        model_reset();

        for (int i = 0; i < 3; i++) cycle(1, 0, 5, 7, 0, 0, 319, 317);

        // Right for three frames, then leave and re-enter the active status.
        cycle(0, 0, 5, 7, 0, 0, 319, 317);
        ticks(3, 5, 7, 0);
        cycle(0, 0, 5, 7, 0, 0, 319, 317);
        cycle(0, 0, 3, 7, 0, 0, 319, 317);
        cycle(0, 0, 3, 0, 0, 0, 319, 317);
        cycle(0, 0, 5, 0, 0, 0, 319, 317);

        // Up-left diagonal into the corner, both step sizes.
        ticks(200, 5, 26, 4);
        cycle(0, 0, 0, 0, 0, 0, 319, 317);
        cycle(0, 0, 5, 0, 0, 0, 319, 317);

        // Opposing keys cancel; duplicate keys count once.
        ticks(10, 5, 4, 7);
        ticks(10, 5, 22, 22);
        cycle(0, 0, 0, 0, 0, 0, 319, 317);
        cycle(0, 0, 5, 0, 0, 0, 319, 317);

        // Hit, ignored second hit, full invincibility window with blinking.
        cycle(0, 0, 5, 0, 0, 1, 319, 317);
        cycle(0, 0, 5, 0, 0, 0, 319, 317);
        ticks(5, 5, 0, 0);
        cycle(0, 0, 5, 0, 0, 1, 319, 317);
        ticks(60, 5, 0, 0);

        // Hit coinciding with a tick, then status drop mid-window.
        cycle(0, 1, 5, 7, 0, 0, 319, 317);
        cycle(0, 0, 5, 7, 0, 1, 319, 317);
        ticks(3, 5, 7, 0);
        cycle(0, 0, 0, 7, 0, 0, 319, 317);
        cycle(0, 0, 5, 0, 0, 0, 319, 317);

        // Sprite window sweep around the idle position.
        cycle(0, 0, 0, 0, 0, 0, 319, 317);
        cycle(0, 0, 5, 0, 0, 0, 319, 317);
        for (int y = 307; y <= 326; y++)
            for (int x = 309; x <= 328; x++)
                cycle(0, 0, 5, 0, 0, 0, x, y);

        // A frame_clk held high yields one tick only.
        for (int i = 0; i < 6; i++) cycle(0, 1, 5, 7, 0, 0, 319, 317);
        for (int i = 0; i < 3; i++) cycle(0, 0, 5, 7, 0, 0, 319, 317);

        // Randomised traffic.
        fr = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 2) == 0) fr = ~fr;
            st = ($urandom_range(0, 59) == 0) ? int'($urandom_range(0, 15)) : 5;
            k0 = kc_tab[$urandom_range(0, 5)];
            k1 = kc_tab[$urandom_range(0, 5)];
            if ($urandom_range(0, 1) == 0) begin
                drx = mx + int'($urandom_range(0, 20)) - 10;
                dry = my + int'($urandom_range(0, 20)) - 10;
            end else begin
                drx = int'($urandom_range(0, 1023));
                dry = int'($urandom_range(0, 1023));
            end
            cycle(0, fr, st, k0, k1, ($urandom_range(0, 29) == 0), drx, dry);
        end

        repeat (3) @(negedge Clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/soul_mover.md
# soul_mover

Parametrised player-soul controller for the battle box. Each frame tick it moves the sprite by keyboard input, with diagonal motion from two simultaneous keys, and clamps the result to a configurable box. It also runs a post-hit invincibility window that blinks the sprite, and generates the hit-test and sprite-ROM address for the color mapper. It sits between the keyboard/status logic and the color mapper, and is the generalised successor to the fixed-size single-key heart mover.

## Interface
Parameters:
- X_INIT, 319: reset/idle X centre
- Y_INIT, 317: reset/idle Y centre
- X_MIN / X_MAX, 251 / 390: inclusive X centre limits
- Y_MIN / Y_MAX, 252 / 366: inclusive Y centre limits
- STEP, 1: pixels moved per tick per axis (1..15)
- SPRITE_W / SPRITE_H, 16 / 16: sprite size, powers of two
- ACTIVE_STATUS, 5: game status code in which the soul is live
- HIT_FRAMES, 60: invincibility length in frame ticks (≥1)
- BLINK_BIT, 2: bit of the invincibility counter that hides the sprite

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- frame_clk  in  1  vertical-sync frame clock (asynchronous level, sampled on Clk)
- status  in  4  game state
- keycode0, keycode1  in  8  two concurrent USB keycodes; 0 means none
- hit  in  1  collision level from bullet logic
- DrawX, DrawY  in  10  current pixel
- PosX, PosY  out  10  current centre position
- is_sprite  out  1  current pixel is drawn from the soul sprite
- sprite_address  out  $clog2(SPRITE_W*SPRITE_H)  sprite ROM index
- invincible  out  1  high during invincibility window

## Operation
- Tick detection: f_d <= frame_clk; tick <= frame_clk & ~f_d. This yields one Clk-wide tick per frame_clk rising edge.
- States:
  - IDLE: status != ACTIVE_STATUS
  - LIVE
  - HURT
- Priority: Reset > status != ACTIVE_STATUS > hit > tick.
- IDLE:
  - Position is forced to (X_INIT, Y_INIT) and the counter to 0 every cycle.
  - Moves to LIVE on the first cycle status == ACTIVE_STATUS.
- Direction decode: OR over both keycodes.
  - 26 (W): up
  - 4 (A): left
  - 22 (S): down
  - 7 (D): right
  - Opposing keys cancel on that axis.
  - A duplicate key counts once.
  - All other codes are ignored.
- Move on tick, in LIVE and HURT:
  - nx = PosX ± STEP, computed in 11-bit signed.
  - If nx < X_MIN then nx = X_MIN; if nx > X_MAX then nx = X_MAX. Y is handled the same way.
  - Axes are independent, so a diagonal against a wall still slides along the free axis.
- LIVE with hit = 1: go to HURT, counter = HIT_FRAMES.
- HURT:
  - On tick the counter decrements; at the tick where the counter goes 1 → 0, return to LIVE.
  - hit is ignored.
- hit and tick in the same cycle while LIVE: the move is applied, HURT is entered, and the counter loads HIT_FRAMES without decrementing.
- Status leaving ACTIVE_STATUS mid-HURT: immediate IDLE, the counter is cleared, and invincible drops next cycle.
- Drawing (combinational from the registers):
  - dx = DrawX − PosX + SPRITE_W/2 and dy = DrawY − PosY + SPRITE_H/2, both 11-bit signed.
  - in_box = 0 ≤ dx < SPRITE_W and 0 ≤ dy < SPRITE_H.
  - is_sprite = in_box & state != IDLE & ~(state == HURT & counter[BLINK_BIT]).
  - sprite_address = dy*SPRITE_W + dx when in_box, else 0. Implemented as a shift, no multiplier.
- invincible = (state == HURT).

## Timing
- Reset values:
  - PosX = X_INIT, PosY = Y_INIT
  - state IDLE, counter 0, f_d 0, tick 0
  - invincible 0
  - is_sprite 0 and sprite_address 0 for all DrawX/DrawY
- Latency:
  - frame_clk is first sampled high at edge k, and tick is high during cycle k→k+1.
  - PosX/PosY show the new value after edge k+1.
- hit sampled at edge j: invincible = 1 after edge j.
- PosX/PosY are driven directly from the position registers, with no extra output register and no one-frame lag.
- is_sprite and sprite_address are combinational, with zero-cycle latency from DrawX/DrawY.
- A frame_clk held high produces only one tick; frame_clk pulses shorter than one Clk are unsupported.

## Test plan
- Reset, then status = 5 and keycode0 = 7 for 3 frame_clk edges → PosX 319→322, PosY stays 317; with status = 3, PosX = 319 next cycle.
- keycode0 = 26, keycode1 = 4, 200 ticks → PosY clamps at 252 after 65 ticks and PosX at 251 after 68 ticks; no wrap, even with STEP = 4 (PosY reaches 252 exactly, not 249).
- keycode0 = 4, keycode1 = 7 → no X motion; keycode0 = keycode1 = 22 → PosY +1 per tick, not +2.
- hit pulse at PosX = 319, PosY = 317 → invincible next cycle; a second hit during HURT is ignored; invincible drops exactly at the 60th subsequent tick; with DrawX = 319, DrawY = 317, is_sprite toggles every 4 ticks.
- hit and tick in the same cycle → position moves and the counter = 60; status → 0 mid-HURT → invincible = 0 and position = init next cycle.
- Position (319, 317) sweep → is_sprite only for DrawX 311..326, DrawY 309..324; sprite_address 0 at (311, 309), 255 at (326, 324), 136 at (319, 317).
